// File: rtl/bresenham_line_sequencer.sv
// Edge sequencer in front of the Bresenham line drawer: latches up to three
// vertices and presents one line or the three edges of a triangle in turn.
module bresenham_line_sequencer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        bla_en,
  input  logic        vertice_num,
  input  logic [47:0] coordinates,
  input  logic        draw_done,
  output logic [7:0]  x0,
  output logic [7:0]  y0,
  output logic [7:0]  x1,
  output logic [7:0]  y1,
  output logic        draw_en,
  output logic        bla_done
);

  typedef enum logic [2:0] {
    IDLE,
    DRAW1,
    WAIT1,
    DRAW2,
    WAIT2,
    DRAW3,
    DONE,
    DONE_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [47:0] vtx;
  logic        tri_mode;
  logic [15:0] v0, v1, v2;

  // Each vertex is packed as {x, y}, so a whole vertex maps onto {xN, yN}.
  assign v0 = vtx[15:0];
  assign v1 = vtx[31:16];
  assign v2 = vtx[47:32];

  // n_rst is active-high despite its name.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state    <= IDLE;
      vtx      <= '0;
      tri_mode <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bla_en) begin
        vtx      <= coordinates;
        tri_mode <= vertice_num;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    {x0, y0}  = '0;
    {x1, y1}  = '0;
    draw_en   = 1'b0;
    bla_done  = 1'b0;
    case (state)
      IDLE: if (bla_en) state_nxt = DRAW1;
      DRAW1: begin
        {x0, y0} = v0;
        {x1, y1} = v1;
        draw_en  = 1'b1;
        if (draw_done) state_nxt = WAIT1;
      end
      WAIT1: state_nxt = tri_mode ? DRAW2 : DONE;
      DRAW2: begin
        {x0, y0} = v0;
        {x1, y1} = v2;
        draw_en  = 1'b1;
        if (draw_done) state_nxt = WAIT2;
      end
      WAIT2: state_nxt = DRAW3;
      DRAW3: begin
        {x0, y0} = v1;
        {x1, y1} = v2;
        draw_en  = 1'b1;
        if (draw_done) state_nxt = DONE;
      end
      DONE: begin
        bla_done  = 1'b1;
        state_nxt = DONE_WAIT;
      end
      DONE_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bresenham_line_sequencer.sv
// Randomised bench for bresenham_line_sequencer; expected output sequences are
// built per primitive from its edge list and checked cycle by cycle.
module tb_bresenham_line_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        bla_en;
  logic        vertice_num;
  logic [47:0] coordinates;
  logic        draw_done;
  logic [7:0]  x0, y0, x1, y1;
  logic        draw_en;
  logic        bla_done;

  int total = 0;
  int bad   = 0;

  bresenham_line_sequencer dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bla_en      (bla_en),
    .vertice_num (vertice_num),
    .coordinates (coordinates),
    .draw_done   (draw_done),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .draw_en     (draw_en),
    .bla_done    (bla_done)
  );

  always #5 clk = ~clk;

  localparam logic [33:0] ZERO = '0;
  localparam logic [33:0] DONE_V = {2'b10, 32'h0};

  function automatic logic [33:0] outv();
    return {bla_done, draw_en, x0, y0, x1, y1};
  endfunction

  task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one primitive from IDLE back to IDLE.
  task automatic run_primitive(input logic [47:0] c, input logic m, input int stall_edge,
                               input int stall_len, input bit dd_one, input bit zero_after,
                               input bit hold_en);
    logic [15:0] vert [3];
    logic [31:0] edges [$];
    int n;
    int cnt;
    logic dd;
    for (int k = 0; k < 3; k++) vert[k] = c[16*k +: 16];
    edges = {};
    edges.push_back({vert[0], vert[1]});
    if (m) begin
      edges.push_back({vert[0], vert[2]});
      edges.push_back({vert[1], vert[2]});
    end
    n = edges.size();

    check_eq("idle", outv(), ZERO);
    coordinates = c;
    vertice_num = m;
    bla_en      = 1'b1;
    draw_done   = 1'($urandom);
    step();
    bla_en = hold_en ? 1'b1 : 1'($urandom);
    if (zero_after) begin
      coordinates = '0;
      vertice_num = 1'b0;
    end

    for (int i = 0; i < n; i++) begin
      cnt = 0;
      forever begin
        check_eq("edge", outv(), {2'b01, edges[i]});
        if (i == stall_edge && cnt < stall_len) dd = 1'b0;
        else if (dd_one || cnt >= 40)          dd = 1'b1;
        else                                    dd = 1'($urandom);
        draw_done = dd;
        if (!zero_after) begin
          coordinates = {$urandom, $urandom};
          vertice_num = 1'($urandom);
        end
        step();
        cnt++;
        if (dd) break;
      end
      if (!(m && i == n - 1)) begin
        check_eq("gap", outv(), ZERO);
        draw_done = 1'($urandom);
        step();
      end
    end
    check_eq("done", outv(), DONE_V);
    draw_done = 1'($urandom);
    step();
    check_eq("done_wait", outv(), ZERO);
    bla_en = hold_en;
    step();
  endtask

  initial begin
    n_rst       = 1'b1;
    bla_en      = 1'b1;
    vertice_num = 1'b0;
    coordinates = 48'h5555_FFFF_0101;
    draw_done   = 1'b1;
    #1;
    check_eq("reset_async", outv(), ZERO);
    repeat (3) begin
      step();
      check_eq("reset", outv(), ZERO);
    end
    n_rst = 1'b0;

    // Directed line, held three cycles before draw_done.
    run_primitive(48'h5555_FFFF_0101, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0);
    // Directed triangle with draw_done tied high.
    run_primitive(48'h5555_FFFF_0101, 1'b1, -1, 0, 1'b1, 1'b0, 1'b0);
    // Five-cycle stall in the second edge.
    run_primitive(48'h5555_FFFF_0101, 1'b1, 1, 5, 1'b1, 1'b0, 1'b0);
    // Inputs zeroed after start must not disturb the latched triangle.
    run_primitive(48'h5555_FFFF_0101, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0);
    // bla_en held high: back-to-back primitives.
    run_primitive(48'h1234_5678_9ABC, 1'b1, -1, 0, 1'b1, 1'b0, 1'b1);
    run_primitive(48'hDEAD_BEEF_CAFE, 1'b0, -1, 0, 1'b1, 1'b0, 1'b1);

    // Idle with bla_en low must stay idle.
    bla_en = 1'b0;
    draw_done = 1'b1;
    repeat (3) begin
      step();
      check_eq("idle_hold", outv(), ZERO);
    end

    // Mid-primitive asynchronous reset during the third edge.
    coordinates = 48'h5555_FFFF_0101;
    vertice_num = 1'b1;
    bla_en      = 1'b1;
    draw_done   = 1'b1;
    step();
    bla_en = 1'b0;
    repeat (4) step();
    check_eq("pre_abort_edge3", outv(), {2'b01, 16'hFFFF, 16'h5555});
    #2 n_rst = 1'b1;
    #1;
    check_eq("abort_async", outv(), ZERO);
    step();
    check_eq("abort_hold", outv(), ZERO);
    n_rst = 1'b0;
    step();
    check_eq("abort_no_done", outv(), ZERO);
    run_primitive(48'h0A0B_0C0D_0E0F, 1'b0, -1, 0, 1'b1, 1'b0, 1'b0);

    // Randomised primitives with random draw_done.
    for (int r = 0; r < 40; r++) begin
      run_primitive({$urandom, $urandom}, 1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), 1'b0, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        bla_en = 1'b0;
        step();
        check_eq("idle_gap", outv(), ZERO);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bresenham_line_sequencer.md
Name: bresenham_line_sequencer

Overview:
- Front-end sequencer for the Bresenham line-drawing engine (BLA) in the 2D GPU pipeline.
- Accepts a packed set of up to three 8-bit (x,y) vertices.
- Issues one line (two vertices) or a closed triangle (three edges) to the line drawer, one edge at a time, with a draw_en / draw_done handshake.
- Signals completion with a one-cycle bla_done pulse.

Parameters:
- None. Coordinate width is fixed at 8 bits; the vertex bus is fixed at 48 bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  asynchronous, active-high reset. The port name follows codebase convention; the reset is asserted when the signal is 1.
- bla_en  input  1  start request; sampled only in IDLE.
- vertice_num  input  1  0 = single line V0->V1; 1 = triangle (three edges). Latched at start.
- coordinates  input  48  packed vertices; latched at start:
  - V0 = [15:0]: x=[15:8], y=[7:0]
  - V1 = [31:16]: x=[31:24], y=[23:16]
  - V2 = [47:32]: x=[47:40], y=[39:32]
- draw_done  input  1  line drawer finished the current edge; sampled only in DRAW states.
- x0, y0  output  8 each  start point of the current edge.
- x1, y1  output  8 each  end point of the current edge.
- draw_en  output  1  high while an edge is presented to the line drawer.
- bla_done  output  1  one-cycle pulse when the whole primitive is complete.

Behaviour:
- Reset (n_rst=1, asynchronous): state=IDLE, latched vertices and mode cleared. All outputs are 0.
- Outputs are Moore (decoded from state and latched registers only).
  - In any non-DRAW state: x0, y0, x1, y1 = 0 and draw_en = 0.
  - bla_done = 1 only in DONE.
- States and transitions (one edge per clock):
  - IDLE: if bla_en=1, latch coordinates and vertice_num and go to DRAW1; else stay.
  - DRAW1: outputs (x0,y0)=V0, (x1,y1)=V1, draw_en=1. If draw_done=1, go to WAIT1; else stay.
  - WAIT1: one cycle with outputs 0. Go to DRAW2 if latched vertice_num=1; else go to DONE.
  - DRAW2: outputs V0 -> V2, draw_en=1. If draw_done=1, go to WAIT2.
  - WAIT2: one cycle with outputs 0, then go to DRAW3.
  - DRAW3: outputs V1 -> V2, draw_en=1. If draw_done=1, go directly to DONE (no wait state).
  - DONE: bla_done=1 for exactly one cycle, then go to DONE_WAIT.
  - DONE_WAIT: one cycle with outputs 0, then go to IDLE.
- Minimum latencies, with draw_done held at 1:
  - Line: DRAW1, WAIT1, DONE, DONE_WAIT, then IDLE (bla_en accepted on the following edge).
  - Triangle: DRAW1, WAIT1, DRAW2, WAIT2, DRAW3, DONE, DONE_WAIT, then IDLE.
- draw_done held high or low is level-sensitive in DRAW states only; it is ignored elsewhere.
- A stuck-high draw_done advances one edge per cycle.
- bla_en is ignored outside IDLE.
- bla_en held high re-triggers a new primitive on the cycle after returning to IDLE.
- Changes to coordinates or vertice_num after the start cycle have no effect until the next start.
- Reset asserted mid-primitive aborts immediately to IDLE with all outputs 0.
- No arithmetic: vertex fields are passed through unmodified (no clipping, no ordering swap).

Test Plan:
- Reset: assert n_rst=1 for 3 cycles with bla_en=1 -> state IDLE; x0=y0=x1=y1=0, draw_en=0, bla_done=0 throughout.
- Single line: release reset with coordinates=48'h5555_FFFF_0101, vertice_num=0, bla_en=1.
  - After one edge: draw_en=1, x0=y0=8'h01, x1=y1=8'hFF; holds while draw_done=0.
  - After draw_done=1 for one cycle: WAIT1 (all outputs 0).
  - Next cycle: bla_done=1.
  - Then one cycle with all outputs 0, then IDLE.
- Triangle: same coordinates, vertice_num=1, draw_done tied 1. Successive cycles:
  - (01,01)->(FF,FF) with draw_en=1
  - zeros
  - (01,01)->(55,55) with draw_en=1
  - zeros
  - (FF,FF)->(55,55) with draw_en=1
  - bla_done=1
  - zeros
  - IDLE
- Stall: in DRAW2, hold draw_done=0 for 5 cycles -> V0->V2 outputs and draw_en=1 stable all 5 cycles; advances to WAIT2 the cycle after draw_done=1.
- Latching: change coordinates to 0 and vertice_num to 0 during DRAW1 of a triangle -> all three edges still use the originally latched values.
- Mid-operation reset: pulse n_rst=1 asynchronously during DRAW3 -> outputs go to 0 immediately with no bla_done pulse; the next bla_en starts at DRAW1.
